// File: rtl/mult_share_ctrl_pkg.sv
// Shared types and constants for the HE multiplier-sharing controller.
package he_mult_pkg;

    // Controller phases: idle/arbitrating, operands settling, product on offer.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mult_state_t;

    localparam int DEFAULT_MULT_WIDTH = 64;
    localparam int DEFAULT_NUM_REQ    = 4;

    // Tag width for a given requester count; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEFAULT_ID_W = id_width(DEFAULT_NUM_REQ);

endpackage

// File: rtl/mult_share_ctrl_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping modulo NUM_REQ.
module rr_arbiter
    import he_mult_pkg::*;
#(
    parameter int NUM_REQ = DEFAULT_NUM_REQ,
    parameter int ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [ID_W-1:0]    grant,
    output logic               grant_valid
);

    // Scan from farthest to nearest offset so the nearest request wins.
    always_comb begin
        int idx;
        logic [ID_W-1:0] sel;
        idx         = 0;
        sel         = '0;
        grant       = '0;
        grant_valid = 1'b0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            idx = (int'(ptr) + off) % NUM_REQ;
            sel = ID_W'(idx);
            if (req[sel]) begin
                grant       = sel;
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/parallel_multiplier.sv
// Slow combinational unsigned array multiplier shared by the requesters.
module parallel_multiplier #(
    parameter int MULT_WIDTH = 64
) (
    input  logic [MULT_WIDTH-1:0]   x,
    input  logic [MULT_WIDTH-1:0]   y,
    output logic [2*MULT_WIDTH-1:0] prod
);

    assign prod = (2*MULT_WIDTH)'(x) * (2*MULT_WIDTH)'(y);

endmodule

// File: rtl/mult_share_ctrl.sv
// Time-shares one combinational multiplier among NUM_REQ requesters.
// Operands are registered on accept and held for MULT_LATENCY cycles so the
// multiplier path can be timed as a multicycle path; the product is then
// captured and offered on a single tagged response channel.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Requesters hold req_valid and operands until they see their
// req_ready bit; the controller holds resp_valid/resp_id/resp_prod until
// resp_ready is seen. At most one req_ready bit is high, and only in IDLE.
module mult_share_ctrl
    import he_mult_pkg::*;
#(
    parameter int MULT_WIDTH   = DEFAULT_MULT_WIDTH,
    parameter int NUM_REQ      = DEFAULT_NUM_REQ,
    parameter int MULT_LATENCY = 2,
    parameter int ID_W         = id_width(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*MULT_WIDTH-1:0] req_x,
    input  logic [NUM_REQ*MULT_WIDTH-1:0] req_y,
    output logic [MULT_WIDTH-1:0]         mult_x,
    output logic [MULT_WIDTH-1:0]         mult_y,
    input  logic [2*MULT_WIDTH-1:0]       mult_prod,
    output logic                          resp_valid,
    input  logic                          resp_ready,
    output logic [ID_W-1:0]               resp_id,
    output logic [2*MULT_WIDTH-1:0]       resp_prod,
    output logic                          busy
);

    localparam int CNT_W = (MULT_LATENCY > 1) ? $clog2(MULT_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULT_LATENCY - 1);
    localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NUM_REQ - 1);

    mult_state_t       state;
    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   grant;
    logic [ID_W-1:0]   next_ptr;
    logic              grant_valid;
    logic              accept;
    logic [CNT_W-1:0]  cnt;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req         (req_valid),
        .ptr         (ptr),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    // Requests are taken only while idle and never during reset.
    assign accept   = (state == IDLE) && grant_valid && !rst;
    assign next_ptr = (grant == LAST_ID) ? '0 : grant + 1'b1;
    assign busy     = (state != IDLE);

    // One-hot ready to the granted requester in the accept cycle only.
    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant] = 1'b1;
        end
    end

    // Controller FSM plus operand, product, tag and round-robin registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= '0;
            cnt        <= '0;
            mult_x     <= '0;
            mult_y     <= '0;
            resp_prod  <= '0;
            resp_id    <= '0;
            resp_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        mult_x  <= req_x[grant*MULT_WIDTH +: MULT_WIDTH];
                        mult_y  <= req_y[grant*MULT_WIDTH +: MULT_WIDTH];
                        resp_id <= grant;
                        ptr     <= next_ptr;
                        cnt     <= CNT_LOAD;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        resp_prod  <= mult_prod;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Bench for mult_share_ctrl: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level model of the controller.
module tb_mult_share_ctrl;

    localparam int W   = 64;
    localparam int N   = 4;
    localparam int LAT = 2;
    localparam int IDW = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N-1:0]     req_valid = '0;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_x = '0;
    logic [N*W-1:0]   req_y = '0;
    logic [W-1:0]     mult_x, mult_y;
    logic [2*W-1:0]   mult_prod;
    logic             resp_valid;
    logic             resp_ready = 1'b1;
    logic [IDW-1:0]   resp_id;
    logic [2*W-1:0]   resp_prod;
    logic             busy;

    mult_share_ctrl #(
        .MULT_WIDTH   (W),
        .NUM_REQ      (N),
        .MULT_LATENCY (LAT),
        .ID_W         (IDW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_x      (req_x),
        .req_y      (req_y),
        .mult_x     (mult_x),
        .mult_y     (mult_y),
        .mult_prod  (mult_prod),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_prod  (resp_prod),
        .busy       (busy)
    );

    parallel_multiplier #(.MULT_WIDTH(W)) u_mul (
        .x    (mult_x),
        .y    (mult_y),
        .prod (mult_prod)
    );

    // ---------------- clock / reset ----------------
    initial begin
        forever #5 clk = ~clk;
    end

    // ---------------- checking helpers ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2*W-1:0] wide_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] aa, bb;
        aa = a;
        bb = b;
        return aa * bb;
    endfunction

    // First valid requester at ptr, ptr+1, ... modulo N; -1 if none.
    function automatic int rr_pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    // ---------------- reference model + scoreboard ----------------
    // Transaction view: an accepted job is "age" cycles old; the product is
    // on offer from age LAT until consumed.
    bit              chk_en = 1'b0;
    bit              m_inflight = 1'b0;
    int              m_age = 0;
    int              m_ptr = 0;
    logic [IDW-1:0]  m_id = '0;
    logic [W-1:0]    m_x = '0;
    logic [W-1:0]    m_y = '0;
    logic [2*W-1:0]  m_prod = '0;
    logic [2*W-1:0]  exp_q[$];
    logic [N-1:0]    acc_mask = '0;

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                bit            e_rv;
                int            pick;
                logic [N-1:0]  e_ready;
                logic [2*W-1:0] e_sb;
                e_rv    = m_inflight && (m_age >= LAT);
                pick    = rr_pick(req_valid, m_ptr);
                e_ready = '0;
                if (!rst && !m_inflight && pick >= 0) e_ready[pick] = 1'b1;

                chk("req_ready",  req_ready,  e_ready);
                chk("busy",       busy,       m_inflight);
                chk("resp_valid", resp_valid, e_rv);
                chk("resp_id",    resp_id,    m_id);
                chk("resp_prod",  resp_prod,  m_prod);
                chk("mult_x",     mult_x,     m_x);
                chk("mult_y",     mult_y,     m_y);

                acc_mask = req_valid & req_ready;

                if (!rst && resp_valid === 1'b1 && resp_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("sb_underflow", 1, 0);
                    end else begin
                        e_sb = exp_q.pop_front();
                        chk("sb_prod", resp_prod, e_sb);
                    end
                end

                if (rst) begin
                    m_inflight = 1'b0;
                    m_age      = 0;
                    m_ptr      = 0;
                    m_id       = '0;
                    m_x        = '0;
                    m_y        = '0;
                    m_prod     = '0;
                    exp_q.delete();
                end else if (!m_inflight) begin
                    if (pick >= 0) begin
                        m_inflight = 1'b1;
                        m_age      = 0;
                        m_id       = IDW'(pick);
                        m_x        = req_x[pick*W +: W];
                        m_y        = req_y[pick*W +: W];
                        m_ptr      = (pick + 1) % N;
                        exp_q.push_back(wide_mul(m_x, m_y));
                    end
                end else if (e_rv) begin
                    if (resp_ready) m_inflight = 1'b0;
                end else begin
                    if (m_age == LAT - 1) m_prod = wide_mul(m_x, m_y);
                    m_age++;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [W-1:0] x, input logic [W-1:0] y);
        req_x[i*W +: W] = x;
        req_y[i*W +: W] = y;
        req_valid[i]    = 1'b1;
    endtask

    function automatic logic [W-1:0] gen_op();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic wait_resp(input int max, output bit ok,
                             output logic [IDW-1:0] id, output logic [2*W-1:0] prod);
        ok   = 1'b0;
        id   = '0;
        prod = '0;
        for (int k = 0; k < max && !ok; k++) begin
            @(negedge clk);
            if (resp_valid === 1'b1) begin
                ok   = 1'b1;
                id   = resp_id;
                prod = resp_prod;
            end
            next_cycle();
        end
    endtask

    task automatic wait_idle(input int max, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < max && !ok; k++) begin
            @(negedge clk);
            if (busy === 1'b0) ok = 1'b1;
            next_cycle();
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit             ok;
        logic [IDW-1:0] gid;
        logic [2*W-1:0] gprod;
        int             g_cyc[$];
        int             g_port[$];
        int             exp_ports[5];
        int             found;
        int             cnt_drop;
        int             cnt_new;

        exp_ports = '{0, 1, 2, 3, 0};

        // Reset, then a single request on port 2.
        rst = 1'b1;
        next_cycle();
        chk_en = 1'b1;
        next_cycle();
        next_cycle();
        rst        = 1'b0;
        resp_ready = 1'b1;
        set_req(2, 64'd3, 64'd5);
        @(negedge clk);
        chk("t1_ready_c0", req_ready, 4'b0100);
        next_cycle();
        req_valid = '0;
        @(negedge clk);
        chk("t1_busy_c1", busy, 1'b1);
        chk("t1_rv_c1", resp_valid, 1'b0);
        next_cycle();
        @(negedge clk);
        chk("t1_rv_c2", resp_valid, 1'b0);
        next_cycle();
        @(negedge clk);
        chk("t1_rv_c3", resp_valid, 1'b1);
        chk("t1_id_c3", resp_id, 2'd2);
        chk("t1_prod_c3", resp_prod, 128'd15);
        next_cycle();

        // Round robin with all four requesters continuously asking.
        rst = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, W'(i + 1), W'(100 + i));
        for (int k = 0; k <= 16; k++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                g_cyc.push_back(k);
                for (int i = 0; i < N; i++) if (req_ready[i]) g_port.push_back(i);
            end
            if (k < 16) next_cycle();
        end
        next_cycle();
        req_valid = '0;
        chk("t2_ngrants", g_port.size(), 5);
        for (int j = 0; j < 5; j++) begin
            chk("t2_port", (j < g_port.size()) ? g_port[j] : -1, exp_ports[j]);
            chk("t2_cycle", (j < g_cyc.size()) ? g_cyc[j] : -1, 4 * j);
        end
        wait_idle(20, ok);
        chk("t2_drain", ok, 1'b1);

        // Widest operands.
        set_req(0, '1, '1);
        @(negedge clk);
        chk("t3_ready", req_ready, 4'b0001);
        next_cycle();
        req_valid = '0;
        wait_resp(10, ok, gid, gprod);
        chk("t3_seen", ok, 1'b1);
        chk("t3_prod", gprod, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
        wait_idle(10, ok);

        // Stalled response, then ptr=2 with ports 1 and 3 pending.
        resp_ready = 1'b0;
        set_req(1, 64'd7, 64'd9);
        @(negedge clk);
        chk("t4_ready", req_ready, 4'b0010);
        next_cycle();
        req_valid = '0;
        wait_resp(10, ok, gid, gprod);
        chk("t4_seen", ok, 1'b1);
        set_req(1, 64'd21, 64'd2);
        set_req(3, 64'd40, 64'd3);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t4_hold_rv", resp_valid, 1'b1);
            chk("t4_hold_id", resp_id, 2'd1);
            chk("t4_hold_prod", resp_prod, 128'd63);
            chk("t4_hold_ready", req_ready, 4'b0000);
            next_cycle();
        end
        resp_ready = 1'b1;
        @(negedge clk);
        chk("t4_rv_last", resp_valid, 1'b1);
        next_cycle();
        @(negedge clk);
        chk("t4_idle", busy, 1'b0);
        chk("t5_first", req_ready, 4'b1000);
        next_cycle();
        req_valid[3] = 1'b0;
        found = -1;
        for (int k = 0; k < 12 && found < 0; k++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) if (req_ready[i]) found = i;
            next_cycle();
        end
        req_valid[1] = 1'b0;
        chk("t5_second", found, 1);
        wait_idle(10, ok);
        chk("t5_drain", ok, 1'b1);

        // Reset during WAIT drops the job and rewinds ptr.
        set_req(2, 64'd11, 64'd13);
        @(negedge clk);
        chk("t6_ready", req_ready, 4'b0100);
        next_cycle();
        req_valid = '0;
        rst       = 1'b1;
        next_cycle();
        rst       = 1'b0;
        req_valid = '1;
        @(negedge clk);
        chk("t6_busy", busy, 1'b0);
        chk("t6_rv", resp_valid, 1'b0);
        chk("t6_regrant", req_ready, 4'b0001);
        next_cycle();
        req_valid = '0;
        cnt_drop = 0;
        cnt_new  = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (resp_valid === 1'b1 && resp_id == 2'd2) cnt_drop++;
            if (resp_valid === 1'b1 && resp_id == 2'd0) cnt_new++;
            next_cycle();
        end
        chk("t6_no_drop", cnt_drop, 0);
        chk("t6_new_resp", cnt_new > 0, 1'b1);

        // Randomized traffic with random back-pressure and rare resets.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (acc_mask[i]) begin
                    req_valid[i] = 1'b0;
                    if ($urandom_range(0, 1) == 0) set_req(i, gen_op(), gen_op());
                end else if (!req_valid[i]) begin
                    if ($urandom_range(0, 3) == 0) set_req(i, gen_op(), gen_op());
                end else if ($urandom_range(0, 31) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            resp_ready = ($urandom_range(0, 3) != 0);
            rst        = ($urandom_range(0, 499) == 0);
            next_cycle();
        end

        // Drain.
        rst        = 1'b0;
        req_valid  = '0;
        resp_ready = 1'b1;
        repeat (20) next_cycle();
        @(negedge clk);
        chk("drain_busy", busy, 1'b0);
        chk("drain_queue", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mult_share_ctrl.md
Name: mult_share_ctrl

Overview:
- Time-shares one external parallel_multiplier instance among NUM_REQ requesters in the HE multiplier unit.
- Arbitrates requests round-robin and registers the operands. Holds them stable for a fixed multicycle settle window, because the array multiplier is combinational and slow.
- Captures the product and returns it on a single tagged response channel with a valid/ready handshake.

Parameters:
- MULT_WIDTH, 64: operand width; product is 2*MULT_WIDTH.
- NUM_REQ, 4: number of requesters; must be >= 2.
- MULT_LATENCY, 2: cycles operands are held before the product is sampled; must be >= 1.
- ID_W, $clog2(NUM_REQ): width of the response tag.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_x  in  NUM_REQ*MULT_WIDTH  operand x; requester i occupies slice [i*MULT_WIDTH +: MULT_WIDTH].
- req_y  in  NUM_REQ*MULT_WIDTH  operand y; same slicing as req_x.
- mult_x  out  MULT_WIDTH  registered operand to the multiplier x input.
- mult_y  out  MULT_WIDTH  registered operand to the multiplier y input.
- mult_prod  in  2*MULT_WIDTH  multiplier prod output.
- resp_valid  out  1  response valid.
- resp_ready  in  1  response consumer ready.
- resp_id  out  ID_W  index of the requester that owns resp_prod.
- resp_prod  out  2*MULT_WIDTH  registered product.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- FSM states: IDLE, WAIT, RESP. Reset value of every state bit and register is listed below.
- Reset (rst high at an edge):
  - state = IDLE, ptr = 0, cnt = 0.
  - mult_x, mult_y, resp_prod, resp_id = 0; resp_valid = 0.
  - Any in-flight operation is dropped and never responded to.
  - req_ready is forced to 0 while rst is high.
- IDLE:
  - grant = first i with req_valid[i], scanning ptr, ptr+1, ... modulo NUM_REQ.
  - req_ready[grant] = 1 combinationally in the same cycle; all other req_ready bits = 0.
  - No valid request: req_ready = 0 and the state holds.
  - On accept:
    - mult_x <= req_x slice, mult_y <= req_y slice, resp_id <= grant.
    - ptr <= (grant+1) mod NUM_REQ, cnt <= MULT_LATENCY-1, state <= WAIT.
- WAIT:
  - req_ready = 0.
  - If cnt == 0: resp_prod <= mult_prod, resp_valid <= 1, state <= RESP.
  - Otherwise cnt <= cnt-1.
- RESP:
  - req_ready = 0.
  - resp_valid, resp_id and resp_prod hold until resp_valid && resp_ready at an edge.
  - On that handshake: resp_valid <= 0, state <= IDLE.
  - No new request is accepted in the handshake cycle.
- Latency: accept in cycle T; resp_valid first high in cycle T+MULT_LATENCY+1.
- Throughput: at best one result per MULT_LATENCY+2 cycles.
- mult_x and mult_y stay stable from T+1 until the next accept. The multiplier path is a MULT_LATENCY-cycle multicycle path, and the SDC is written accordingly.
- Requesters must hold req_valid and their operands until they see req_ready. A requester that deasserts req_valid before grant is simply skipped.
- ptr advances only on accept. A stalled response does not move ptr.
- The arithmetic is unmodified: resp_prod is exactly the mult_prod value sampled at the end of the WAIT window, unsigned, 2*MULT_WIDTH bits.

Decomposition:
- Package he_mult_pkg holds:
  - mult_state_t enum {IDLE, WAIT, RESP};
  - default MULT_WIDTH = 64;
  - a localparam helper for ID_W.
- Sub-module rr_arbiter #(NUM_REQ), combinational:
  - inputs: req vector and ptr;
  - outputs: grant index and a grant_valid flag.
- The ptr register and all remaining logic stay in mult_share_ctrl.
- The testbench instantiates parallel_multiplier as the external datapath.

Test Plan:
- After reset, only req_valid[2] is high with x=3, y=5 → req_ready[2]=1 in cycle 0; resp_valid=1 in cycle 3 with resp_id=2 and resp_prod=15.
- All four req_valid are held high with resp_ready=1 → grants occur in order 0,1,2,3,0, one every 4 cycles (MULT_LATENCY=2).
- x = y = 64'hFFFF_FFFF_FFFF_FFFF → resp_prod = 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001.
- resp_ready is held low for 5 cycles in RESP → resp_valid, resp_id and resp_prod stay stable; req_ready stays 0 on every port; ptr is unchanged; IDLE is reached the cycle after resp_ready rises.
- With ptr=2, req_valid[1] and req_valid[3] are held high → port 3 is granted first, then port 1.
- rst is pulsed during WAIT → the next cycle shows busy=0 and resp_valid=0; the dropped request never produces a response; the next grant starts scanning from port 0.
